// File: rtl/hba_arbiter.sv
// Round-robin HBA bus arbiter with hold-until-release grants,
// a one-cycle turnaround and a transfer watchdog.
module hba_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   hba_clk,
    input  logic                   hba_resetq,
    input  logic [NUM_MASTERS-1:0] hba_mrequest,
    input  logic                   hba_select,
    input  logic                   hba_xferack,
    output logic [NUM_MASTERS-1:0] hba_mgrant,
    output logic                   hba_xferack_timeout,
    output logic                   arb_busy,
    output logic                   arb_err,
    output logic [2:0]             arb_err_master,
    input  logic                   arb_err_clr
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

    localparam logic [2:0]  LAST_RST = 3'(NUM_MASTERS - 1);
    localparam logic        WD_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [15:0] TERM     =
        (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic [2:0]             owner_q, owner_d;
    logic [2:0]             last_q, last_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   to_q, to_d;
    logic                   err_q, err_d;
    logic [2:0]             errm_q, errm_d;

    logic [2:0] win;
    logic       found;
    logic       owner_req;
    logic       stall;

    // First requester at or after last+1, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!found && hba_mrequest[i] &&
                    i == (int'(last_q) + k) % NUM_MASTERS) begin
                    found = 1'b1;
                    win   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (3'(i) == owner_q) begin
                owner_req = hba_mrequest[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (found) begin
                    state_d = GRANT;
                    owner_d = win;
                    last_d  = win;
                    busy_d  = 1'b1;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        grant_d[i] = (3'(i) == win);
                    end
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_d = TURN;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // A stalled transfer counts up; the timeout never revokes the grant.
    always_comb begin
        cnt_d  = '0;
        to_d   = 1'b0;
        err_d  = err_q;
        errm_d = errm_q;
        stall  = WD_EN && (state_q == GRANT) &&
                 hba_select && !hba_xferack;
        if (stall) begin
            if (cnt_q == TERM) begin
                to_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        if (to_d) begin
            err_d  = 1'b1;
            errm_d = owner_q;
        end else if (arb_err_clr) begin
            err_d  = 1'b0;
            errm_d = '0;
        end
    end

    always_ff @(posedge hba_clk or negedge hba_resetq) begin
        if (!hba_resetq) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
            errm_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            err_q   <= err_d;
            errm_q  <= errm_d;
        end
    end

    assign hba_mgrant          = grant_q;
    assign arb_busy            = busy_q;
    assign hba_xferack_timeout = to_q;
    assign arb_err             = err_q;
    assign arb_err_master      = errm_q;

endmodule

// File: tb/tb_hba_arbiter.sv
// Bench for hba_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_hba_arbiter;

    localparam int NM = 4;
    localparam int TO = 8;

    logic          hba_clk = 1'b0;
    logic          hba_resetq = 1'b0;
    logic [NM-1:0] req = '0;
    logic          sel = 1'b0;
    logic          ack = 1'b0;
    logic          clr = 1'b0;
    logic [NM-1:0] hba_mgrant;
    logic          hba_xferack_timeout;
    logic          arb_busy;
    logic          arb_err;
    logic [2:0]    arb_err_master;

    int nvec = 0;
    int nerr = 0;

    int m_owner, m_last, m_cnt, m_errm;
    bit m_turn, m_to, m_err;

    always #5 hba_clk = ~hba_clk;

    hba_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
        .hba_clk(hba_clk),
        .hba_resetq(hba_resetq),
        .hba_mrequest(req),
        .hba_select(sel),
        .hba_xferack(ack),
        .hba_mgrant(hba_mgrant),
        .hba_xferack_timeout(hba_xferack_timeout),
        .arb_busy(arb_busy),
        .arb_err(arb_err),
        .arb_err_master(arb_err_master),
        .arb_err_clr(clr)
    );

    function automatic void model_reset();
        m_owner = -1;
        m_turn  = 0;
        m_last  = NM - 1;
        m_cnt   = 0;
        m_to    = 0;
        m_err   = 0;
        m_errm  = 0;
    endfunction

    // One bus clock of the arbitration rules, from the applied inputs.
    function automatic void model_step();
        int  prev = m_owner;
        bit  fire = 0;
        if (m_owner >= 0 && sel && !ack) begin
            if (m_cnt == TO - 1) begin
                fire  = 1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_turn  = 1;
            end
        end else if (m_turn) begin
            m_turn = 0;
        end else begin
            for (int k = 1; k <= NM; k++) begin
                int c = (m_last + k) % NM;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_last  = c;
                end
            end
        end
        m_to = fire;
        if (fire) begin
            m_err  = 1;
            m_errm = prev;
        end else if (clr) begin
            m_err  = 0;
            m_errm = 0;
        end
    endfunction

    function automatic logic [NM-1:0] m_grant();
        logic [NM-1:0] g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic tick();
        model_step();
        @(posedge hba_clk);
        #1;
    endtask

    task automatic do_reset();
        hba_resetq = 1'b0;
        req = '0;
        sel = 1'b0;
        ack = 1'b0;
        clr = 1'b0;
        repeat (2) @(posedge hba_clk);
        #1;
        model_reset();
        hba_resetq = 1'b1;
    endtask

    task automatic test_reset();
        hba_resetq = 1'b0;
        req = 4'b0011;
        #3;
        nvec++;
        if (hba_mgrant !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_grant got %b want 0000", hba_mgrant);
        end
        nvec++;
        if ({arb_busy, hba_xferack_timeout, arb_err} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_flags got %b want 000",
                     {arb_busy, hba_xferack_timeout, arb_err});
        end
        nvec++;
        if (arb_err_master !== 3'd0) begin
            nerr++;
            $display("FAIL reset_errm got %0d want 0", arb_err_master);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [NM-1:0] exp [$] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                   4'b0001, 4'b0000, 4'b0000, 4'b0001};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req = (c == 5) ? 4'b0000 : 4'b0001;
            tick();
            nvec++;
            if (hba_mgrant !== exp[c] || arb_busy !== |exp[c]) begin
                nerr++;
                $display("FAIL single c%0d got %b/%b want %b", c,
                         hba_mgrant, arb_busy, exp[c]);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [NM-1:0] rq  [$] = '{4'b0011, 4'b0011, 4'b0010, 4'b0011,
                                   4'b0011, 4'b0011, 4'b0001, 4'b0011,
                                   4'b0011};
        logic [NM-1:0] exp [$] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                   4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                   4'b0001};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req = rq[c];
            tick();
            nvec++;
            if (hba_mgrant !== exp[c]) begin
                nerr++;
                $display("FAIL simul c%0d got %b want %b", c,
                         hba_mgrant, exp[c]);
            end
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_no_preempt();
        logic [NM-1:0] rq  [$] = '{4'b0001, 4'b0011, 4'b0011, 4'b0011,
                                   4'b0010, 4'b0010, 4'b0010};
        logic [NM-1:0] exp [$] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                   4'b0000, 4'b0000, 4'b0010};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req = rq[c];
            tick();
            nvec++;
            if (hba_mgrant !== exp[c]) begin
                nerr++;
                $display("FAIL preempt c%0d got %b want %b", c,
                         hba_mgrant, exp[c]);
            end
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        req = 4'b0010;
        tick();
        sel = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            nvec++;
            if (hba_xferack_timeout !== (j == 8)) begin
                nerr++;
                $display("FAIL wd_pulse j%0d got %b want %b", j,
                         hba_xferack_timeout, j == 8);
            end
            if (j == 8) begin
                nvec++;
                if (arb_err !== 1'b1 || arb_err_master !== 3'd1 ||
                    hba_mgrant !== 4'b0010) begin
                    nerr++;
                    $display("FAIL wd_err got %b/%0d/%b want 1/1/0010",
                             arb_err, arb_err_master, hba_mgrant);
                end
            end
        end
        sel = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        nvec++;
        if (arb_err !== 1'b0 || arb_err_master !== 3'd0) begin
            nerr++;
            $display("FAIL wd_clr got %b/%0d want 0/0",
                     arb_err, arb_err_master);
        end
        sel = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            ack = (j == 8);
            tick();
            nvec++;
            if (hba_xferack_timeout !== 1'b0 || arb_err !== 1'b0) begin
                nerr++;
                $display("FAIL wd_ack_suppress j%0d got %b/%b want 0/0",
                         j, hba_xferack_timeout, arb_err);
            end
        end
        ack = 1'b0;
        clr = 1'b1;
        repeat (8) tick();
        nvec++;
        if ({hba_xferack_timeout, arb_err} !== 2'b11 ||
            arb_err_master !== 3'd1) begin
            nerr++;
            $display("FAIL wd_clr_race got %b%b/%0d want 11/1",
                     hba_xferack_timeout, arb_err, arb_err_master);
        end
        sel = 1'b0;
        tick();
        clr = 1'b0;
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        nvec++;
        if (hba_mgrant !== 4'b0010) begin
            nerr++;
            $display("FAIL rstmid_pre got %b want 0010", hba_mgrant);
        end
        #2;
        hba_resetq = 1'b0;
        #1;
        nvec++;
        if (hba_mgrant !== 4'b0000 || arb_busy !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_async got %b/%b want 0000/0",
                     hba_mgrant, arb_busy);
        end
        @(posedge hba_clk);
        #1;
        model_reset();
        hba_resetq = 1'b1;
        req = 4'b0011;
        tick();
        nvec++;
        if (hba_mgrant !== 4'b0001) begin
            nerr++;
            $display("FAIL rstmid_post got %b want 0001", hba_mgrant);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_glitch();
        logic [NM-1:0] rq  [$] = '{4'b0001, 4'b0011, 4'b0001, 4'b0001,
                                   4'b0001, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0000};
        logic [NM-1:0] exp [$] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                   4'b0001, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0000};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req = rq[c];
            tick();
            nvec++;
            if (hba_mgrant !== exp[c] || arb_busy !== |exp[c]) begin
                nerr++;
                $display("FAIL glitch c%0d got %b/%b want %b", c,
                         hba_mgrant, arb_busy, exp[c]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            sel = ($urandom_range(3) != 0);
            ack = ($urandom_range(15) == 0);
            clr = ($urandom_range(31) == 0);
            tick();
            nvec++;
            if (hba_mgrant !== m_grant() || arb_busy !== (m_owner >= 0)) begin
                nerr++;
                $display("FAIL rand_grant c%0d got %b/%b want %b", c,
                         hba_mgrant, arb_busy, m_grant());
            end
            nvec++;
            if (hba_xferack_timeout !== m_to || arb_err !== m_err ||
                arb_err_master !== 3'(m_errm)) begin
                nerr++;
                $display("FAIL rand_wd c%0d got %b/%b/%0d want %b/%b/%0d",
                         c, hba_xferack_timeout, arb_err, arb_err_master,
                         m_to, m_err, m_errm);
            end
        end
        req = '0;
        sel = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_simultaneous();
        test_no_preempt();
        test_watchdog();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hba_arbiter.md
Name: hba_arbiter

Overview:
- Bus arbiter directly downstream of every HBA bus master, including the serial bridge's master port.
- Collects hba_mrequest from up to 8 masters and returns a one-hot hba_mgrant using round-robin priority.
- Holds the grant until the owning master drops its request, then inserts one idle turnaround cycle.
- Includes a transfer watchdog: if no slave acknowledges a transfer, it forces a one-cycle timeout acknowledge and latches an error so the granted master cannot hang the bus.

Parameters:
- NUM_MASTERS, 2: number of requesting masters (1..8).
- TIMEOUT_CYCLES, 1024: cycles of hba_select without hba_xferack before a forced ack. 0 disables the watchdog. Must fit in 16 bits.

Ports:
- hba_clk  in  1  bus clock.
- hba_resetq  in  1  asynchronous active-low reset.
- hba_mrequest  in  NUM_MASTERS  per-master request, bit i = master i.
- hba_select  in  1  OR'd bus select (transfer in progress).
- hba_xferack  in  1  OR'd slave acknowledge.
- hba_mgrant  out  NUM_MASTERS  one-hot grant, all zero when no owner.
- hba_xferack_timeout  out  1  forced ack pulse, ORed externally into hba_xferack.
- arb_busy  out  1  high while any grant is asserted.
- arb_err  out  1  sticky timeout flag.
- arb_err_master  out  3  index of the master that owned the bus at the last timeout.
- arb_err_clr  in  1  synchronous clear of arb_err and arb_err_master.

Behaviour:
- Reset (hba_resetq=0, asynchronous):
  - State=IDLE.
  - hba_mgrant=0, hba_xferack_timeout=0, arb_busy=0, arb_err=0, arb_err_master=0.
  - Round-robin pointer last=NUM_MASTERS-1, so master 0 has first priority.
  - Timeout counter=0.
- All outputs are registered.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If any request bit is set, pick the first set bit searching from (last+1) mod NUM_MASTERS upward with wrap.
  - Next cycle: hba_mgrant has only that bit set, arb_busy=1, last=winner, state=GRANT.
  - Grant latency is exactly 1 clock from request sampled in IDLE.
  - No request: stay in IDLE with outputs at 0.
- GRANT:
  - Grant stays stable while hba_mrequest[owner]=1. Other requests are ignored; there is no preemption.
  - When hba_mrequest[owner]=0 is sampled, the next cycle has hba_mgrant=0, arb_busy=0, state=TURN.
  - The owner dropping its request in the same cycle as a timeout still releases normally. The timeout pulse is still issued.
- TURN:
  - Exactly one cycle, no grant, so the bus is guaranteed idle between owners. Then go to IDLE.
  - Minimum back-to-back handover is therefore: release sampled, then TURN, then IDLE arbitration, then new grant.
- Round robin: after master i is served, master i+1 (wrap) has highest priority.
  - With N masters requesting continuously, each is granted once per N grants.
- Request glitch: a request that drops while in IDLE, before it is granted, is simply not granted. No memory of it is kept.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each cycle in GRANT with hba_select=1 and hba_xferack=0.
  - It clears on hba_xferack=1, on hba_select=0, or outside GRANT.
  - When the counter reaches TIMEOUT_CYCLES-1 and the clearing conditions are still false:
    - hba_xferack_timeout pulses high for 1 cycle.
    - arb_err is set to 1.
    - arb_err_master is set to the owner index.
    - The counter is cleared.
  - The bus grant is not revoked; the master completes as if acknowledged.
  - A real hba_xferack in the same cycle as the terminal count suppresses the timeout pulse.
- arb_err_clr=1 clears arb_err and arb_err_master next cycle. A simultaneous new timeout wins: the error is set with the new index.
- Reset mid-grant: grant drops immediately (asynchronous) and the counter clears. After release, arbitration restarts from master 0 priority.
- With NUM_MASTERS=1 the block degenerates to grant/release with TURN and watchdog intact.

Test Plan:
- Single request: hba_mrequest=2'b01 at cycle 0 -> hba_mgrant=2'b01 and arb_busy=1 at cycle 1. Drop the request at cycle 5 -> mgrant=0 at cycle 6, with one idle cycle before any new grant.
- Simultaneous requests: hba_mrequest=2'b11 held from reset -> grants alternate 01, 00 (turn), 10, 00, 01…. Each grant is held until that master drops its request.
- No preemption: master 0 granted, master 1 requests mid-grant -> mgrant stays 01 until master 0 releases, then 10 after one TURN cycle.
- Watchdog: TIMEOUT_CYCLES=8, master 1 granted, hba_select=1, no xferack -> hba_xferack_timeout high exactly on the 8th select cycle, arb_err=1, arb_err_master=1. arb_err_clr then clears both. With xferack on cycle 8 -> no pulse.
- Reset mid-operation: assert hba_resetq=0 during GRANT -> mgrant=0 with no clock edge. After release, a request 2'b11 is granted to master 0 first.
- Glitch: pulse hba_mrequest[1] for 1 cycle while master 0 owns the bus -> master 1 is never granted, and arb returns to IDLE with mgrant=0.
